// File: rtl/score_display_driver.sv
// rtl/score_display_driver.sv - binary count to two-digit multiplexed 7-segment display
// Optional build macro: LEADING_ZERO_BLANK_EN (blank a zero tens digit).
module score_display_driver #(
    parameter int BW          = 7,
    parameter int REFRESH_DIV = 1024
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [BW-1:0] value_i,
    output logic [6:0]    seg_o,
    output logic [1:0]    dig_sel_o,
    output logic          busy_o,
    output logic          ovf_o
);
    localparam int CW = $clog2(BW + 1);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [3:0] DASH = 4'hF;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   last_val_q, last_val_d;
    logic [BW-1:0]   shadow_q, shadow_d;
    logic [3:0]      tens_q, tens_d, ones_q, ones_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_pend_q, ovf_pend_d;
    logic [3:0]      disp_tens_q, disp_tens_d, disp_ones_q, disp_ones_d;
    logic            ovf_q, ovf_d;
    logic [RW-1:0]   ref_cnt_q, ref_cnt_d;
    logic [1:0]      dig_sel_q, dig_sel_d;
    logic [6:0]      seg_q, seg_d;
    logic [3:0]      adj_tens, adj_ones, sel_digit;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b0111111;
            4'd1:    seg_decode = 7'b0000110;
            4'd2:    seg_decode = 7'b1011011;
            4'd3:    seg_decode = 7'b1001111;
            4'd4:    seg_decode = 7'b1100110;
            4'd5:    seg_decode = 7'b1101101;
            4'd6:    seg_decode = 7'b1111101;
            4'd7:    seg_decode = 7'b0000111;
            4'd8:    seg_decode = 7'b1111111;
            4'd9:    seg_decode = 7'b1101111;
            default: seg_decode = 7'b1000000;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        last_val_d  = last_val_q;
        shadow_d    = shadow_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        cnt_d       = cnt_q;
        ovf_pend_d  = ovf_pend_q;
        disp_tens_d = disp_tens_q;
        disp_ones_d = disp_ones_q;
        ovf_d       = ovf_q;
        adj_tens    = (tens_q >= 4'd5) ? tens_q + 4'd3 : tens_q;
        adj_ones    = (ones_q >= 4'd5) ? ones_q + 4'd3 : ones_q;
        case (state_q)
            IDLE: begin
                if (value_i != last_val_q) begin
                    shadow_d   = value_i;
                    last_val_d = value_i;
                    tens_d     = 4'd0;
                    ones_d     = 4'd0;
                    cnt_d      = '0;
                    if (8'(value_i) > 8'd99) begin
                        ovf_pend_d = 1'b1;
                        state_d    = LOAD;
                    end else begin
                        ovf_pend_d = 1'b0;
                        state_d    = SHIFT;
                    end
                end
            end
            SHIFT: begin
                {tens_d, ones_d, shadow_d} = {adj_tens, adj_ones, shadow_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(BW - 1)) state_d = LOAD;
            end
            LOAD: begin
                disp_tens_d = ovf_pend_q ? DASH : tens_q;
                disp_ones_d = ovf_pend_q ? DASH : ones_q;
                ovf_d       = ovf_pend_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // seg_q is looked up for the digit that will be selected after this edge
    always_comb begin
        ref_cnt_d = ref_cnt_q + 1'b1;
        dig_sel_d = dig_sel_q;
        if (ref_cnt_q == RW'(REFRESH_DIV - 1)) begin
            ref_cnt_d = '0;
            dig_sel_d = ~dig_sel_q;
        end
        sel_digit = dig_sel_d[1] ? disp_tens_q : disp_ones_q;
        seg_d     = seg_decode(sel_digit);
`ifdef LEADING_ZERO_BLANK_EN
        if (dig_sel_d[1] && disp_tens_q == 4'd0 && !ovf_q) seg_d = 7'b0000000;
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            last_val_q  <= '0;
            shadow_q    <= '0;
            tens_q      <= 4'd0;
            ones_q      <= 4'd0;
            cnt_q       <= '0;
            ovf_pend_q  <= 1'b0;
            disp_tens_q <= 4'd0;
            disp_ones_q <= 4'd0;
            ovf_q       <= 1'b0;
            ref_cnt_q   <= '0;
            dig_sel_q   <= 2'b01;
            seg_q       <= 7'b0111111;
        end else begin
            state_q     <= state_d;
            last_val_q  <= last_val_d;
            shadow_q    <= shadow_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            cnt_q       <= cnt_d;
            ovf_pend_q  <= ovf_pend_d;
            disp_tens_q <= disp_tens_d;
            disp_ones_q <= disp_ones_d;
            ovf_q       <= ovf_d;
            ref_cnt_q   <= ref_cnt_d;
            dig_sel_q   <= dig_sel_d;
            seg_q       <= seg_d;
        end
    end

    assign seg_o     = seg_q;
    assign dig_sel_o = dig_sel_q;
    assign busy_o    = (state_q != IDLE);
    assign ovf_o     = ovf_q;
endmodule
